demux1_8_buf: RTL

//  1-to-8 buffered demultiplexer; inverse of the 8:1 32-bit operand mux.

---
 rtl/demux1_8_buf.sv | 85 ++++++++
 1 files changed

// File: rtl/demux1_8_buf.sv
// 1-to-8 buffered demultiplexer: one valid/ready producer port fans out to eight
// holding registers, each released by its own consumer ack.
module demux1_8_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ack,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0][WIDTH-1:0] data_q;
  logic [7:0]            valid_q;
  logic [7:0]            valid_d;
  logic [7:0]            wr_en;
  logic [CNT_W-1:0]      stall_q;
  logic [CNT_W-1:0]      stall_d;
  logic                  accept;

  // A full slot can still accept when its consumer drains it in the same cycle.
  assign in_ready = ~valid_q[in_sel] | out_ack[in_sel];
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      assign wr_en[gi]   = accept & (in_sel == 3'(gi));
      assign valid_d[gi] = wr_en[gi] | (valid_q[gi] & ~out_ack[gi]);
    end
  endgenerate

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      stall_q <= '0;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
      for (int k = 0; k < 8; k++) begin
        if (wr_en[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out4      = data_q[4];
  assign out5      = data_q[5];
  assign out6      = data_q[6];
  assign out7      = data_q[7];
  assign out_valid = valid_q;
  assign stall_cnt = stall_q;

endmodule
